prog_sequencer: RTL and testbench

//  Upstream driver of the processor top level: resets the DUT, then launches NUM_PROGS programs back-to-back
//  via the req/ack handshake and measures cycles per program.

---
 rtl/prog_sequencer_pkg.sv | 20 ++
 rtl/prog_sequencer_if.sv | 11 +
 rtl/sat_counter.sv | 23 ++
 rtl/prog_sequencer.sv | 102 ++++++++++
 tb/tb_prog_sequencer.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared types and helpers for the program sequencer.
package prog_sequencer_pkg;

    localparam int unsigned DEFAULT_CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DUT,
        S_REQ,
        S_BLANK,
        S_RUN,
        S_RECORD,
        S_DONE
    } seq_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Init/req/ack handshake between the sequencer and the processor top level.
interface prog_sequencer_if;

    logic dut_init;
    logic dut_req;
    logic dut_ack;

    modport master (output dut_init, output dut_req, input dut_ack);
    modport slave  (input dut_init, input dut_req, output dut_ack);

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q,
    output logic         max
);

    assign max = &q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en && !max) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Resets the processor, launches NUM_PROGS programs via req/ack and reports cycles per program.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int unsigned NUM_PROGS  = 3,
    parameter int unsigned REQ_CYCLES = 2,
    parameter int unsigned ACK_BLANK  = 2,
    parameter int unsigned CW         = DEFAULT_CW,
    parameter int unsigned TIMEOUT    = 32'hFFFF,
    localparam int unsigned IW        = idx_width(NUM_PROGS)
) (
    input  logic                    clk,
    input  logic                    init,
    input  logic                    start,
    prog_sequencer_if.master        dut,
    output logic                    busy,
    output logic                    done,
    output logic [IW-1:0]           prog_idx,
    output logic [CW-1:0]           cyc_count,
    output logic                    cyc_valid,
    output logic                    timeout_err
);

    localparam int unsigned PMAX = (REQ_CYCLES > ACK_BLANK) ? REQ_CYCLES : ACK_BLANK;
    localparam int unsigned PW   = $clog2(PMAX + 1);

    seq_state_t    state_q, state_d;
    logic [CW-1:0] run_cnt;
    logic          run_max;
    logic [PW-1:0] ph_cnt;
    logic          ph_max;
    logic          req_end, blank_end, hung, last_prog;

    sat_counter #(.W(CW)) u_run_cnt (
        .clk (clk),
        .rst (init),
        .clr (state_q == S_REQ),
        .en  (state_q inside {S_BLANK, S_RUN}),
        .q   (run_cnt),
        .max (run_max)
    );

    // Phase timer restarts on every state change, so it times REQ and BLANK alike.
    sat_counter #(.W(PW)) u_ph_cnt (
        .clk (clk),
        .rst (init),
        .clr (state_d != state_q),
        .en  (1'b1),
        .q   (ph_cnt),
        .max (ph_max)
    );

    assign req_end   = (ph_cnt == PW'(REQ_CYCLES - 1)) || ph_max;
    assign blank_end = (ph_cnt == PW'(ACK_BLANK - 1)) || ph_max;
    // A stalled saturated count can never reach a larger TIMEOUT; treat it as hung too.
    assign hung      = (run_cnt == CW'(TIMEOUT)) || run_max;
    assign last_prog = prog_idx == IW'(NUM_PROGS - 1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RST_DUT;
            S_RST_DUT:      state_d = S_REQ;
            S_REQ:          if (req_end) state_d = (ACK_BLANK == 0) ? S_RUN : S_BLANK;
            S_BLANK:        if (blank_end) state_d = S_RUN;
            S_RUN:          if (dut.dut_ack || hung) state_d = S_RECORD;
            S_RECORD:       state_d = (timeout_err || last_prog) ? S_DONE : S_REQ;
            default:        state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q      <= S_IDLE;
            dut.dut_init <= 1'b0;
            dut.dut_req  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            prog_idx     <= '0;
            cyc_count    <= '0;
            cyc_valid    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dut.dut_init <= state_d == S_RST_DUT;
            dut.dut_req  <= state_d == S_REQ;
            busy         <= !(state_d inside {S_IDLE, S_DONE});
            done         <= state_d == S_DONE;
            cyc_valid    <= state_d == S_RECORD;
            if (state_d == S_RECORD) cyc_count <= run_cnt;
            if ((state_q inside {S_IDLE, S_DONE}) && start) begin
                prog_idx    <= '0;
                timeout_err <= 1'b0;
            end else if (state_q == S_RECORD && state_d == S_REQ) begin
                prog_idx <= prog_idx + IW'(1);
            end
            if (state_q == S_RUN && !dut.dut_ack && hung) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench: per-cycle plan of inputs and expected outputs built from phase lengths, plus literal logs.
module tb_prog_sequencer;

    localparam int NP = 3;
    localparam int RC = 2;
    localparam int AB = 2;
    localparam int NI = 3;
    localparam int TMO  [NI] = '{65535, 20, 15};
    localparam int MAXV [NI] = '{65535, 65535, 15};

    typedef struct packed {
        logic        init;
        logic        req;
        logic        busy;
        logic        done;
        logic        valid;
        logic        terr;
        logic [15:0] idx;
        logic [15:0] cnt;
    } obs_t;

    typedef struct packed {
        logic rst;
        logic start;
        logic ack;
        obs_t o;
    } step_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0] ini, start, ack;
    logic [NI-1:0] busy, done, valid, terr;
    logic [1:0]    idx0, idx1, idx2;
    logic [15:0]   cnt0, cnt1;
    logic [3:0]    cnt2;

    prog_sequencer_if bus0 ();
    prog_sequencer_if bus1 ();
    prog_sequencer_if bus2 ();
    assign bus0.dut_ack = ack[0];
    assign bus1.dut_ack = ack[1];
    assign bus2.dut_ack = ack[2];

    prog_sequencer u0 (
        .clk(clk), .init(ini[0]), .start(start[0]), .dut(bus0), .busy(busy[0]), .done(done[0]),
        .prog_idx(idx0), .cyc_count(cnt0), .cyc_valid(valid[0]), .timeout_err(terr[0])
    );
    prog_sequencer #(.TIMEOUT(20)) u1 (
        .clk(clk), .init(ini[1]), .start(start[1]), .dut(bus1), .busy(busy[1]), .done(done[1]),
        .prog_idx(idx1), .cyc_count(cnt1), .cyc_valid(valid[1]), .timeout_err(terr[1])
    );
    prog_sequencer #(.CW(4), .TIMEOUT(15)) u2 (
        .clk(clk), .init(ini[2]), .start(start[2]), .dut(bus2), .busy(busy[2]), .done(done[2]),
        .prog_idx(idx2), .cyc_count(cnt2), .cyc_valid(valid[2]), .timeout_err(terr[2])
    );

    step_t plan  [NI][$];
    obs_t  cur   [NI];
    int    log_q [NI][$];
    int    n_chk = 0;
    int    n_pass = 0;

    function automatic obs_t get_obs(input int i);
        obs_t o;
        o = '0;
        case (i)
            0: begin o.init = bus0.dut_init; o.req = bus0.dut_req; o.idx = 16'(idx0); o.cnt = cnt0; end
            1: begin o.init = bus1.dut_init; o.req = bus1.dut_req; o.idx = 16'(idx1); o.cnt = cnt1; end
            default: begin
                o.init = bus2.dut_init; o.req = bus2.dut_req; o.idx = 16'(idx2); o.cnt = 16'(cnt2);
            end
        endcase
        o.busy  = busy[i];
        o.done  = done[i];
        o.valid = valid[i];
        o.terr  = terr[i];
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("init=%b req=%b busy=%b done=%b idx=%0d cnt=%0d valid=%b terr=%b",
                         o.init, o.req, o.busy, o.done, o.idx, o.cnt, o.valid, o.terr);
    endfunction

    task automatic push(input int i, input logic r, input logic s, input logic a);
        step_t e;
        e.rst = r; e.start = s; e.ack = a; e.o = cur[i];
        plan[i].push_back(e);
    endtask

    task automatic set_phase(input int i, input logic in, input logic rq, input logic bz,
                             input logic dn, input int p);
        cur[i].init = in; cur[i].req = rq; cur[i].busy = bz; cur[i].done = dn;
        cur[i].idx = 16'(p); cur[i].valid = 1'b0;
    endtask

    task automatic push_init(input int i);
        cur[i] = '0;
        push(i, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic push_idle(input int i, input int n);
        cur[i].init = 1'b0; cur[i].req = 1'b0; cur[i].valid = 1'b0;
        for (int k = 0; k < n; k++) push(i, 1'b0, 1'b0, 1'b0);
    endtask

    // a0..a2: RUN cycle (0-based) in which ack is high for each program, -1 for never.
    task automatic push_run(input int i, input int a0, input int a1, input int a2,
                            input logic early, input logic bstart);
        int  acks [NP];
        int  val;
        logic hit;
        acks = '{a0, a1, a2};
        cur[i].terr = 1'b0;
        set_phase(i, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        push(i, 1'b0, 1'b1, 1'b0);
        for (int p = 0; p < NP; p++) begin
            hit = 1'b0;
            val = 0;
            for (int k = 0; k < RC; k++) begin
                set_phase(i, 1'b0, 1'b1, 1'b1, 1'b0, p); push(i, 1'b0, bstart, early);
            end
            for (int k = 0; k < AB; k++) begin
                set_phase(i, 1'b0, 1'b0, 1'b1, 1'b0, p); push(i, 1'b0, bstart, early);
            end
            for (int j = 0; j < 100000; j++) begin
                set_phase(i, 1'b0, 1'b0, 1'b1, 1'b0, p);
                push(i, 1'b0, bstart, (j == 0) ? early : 1'b0);
                val = (AB + j < MAXV[i]) ? AB + j : MAXV[i];
                if (j == acks[p]) begin hit = 1'b1; break; end
                if (val == TMO[i]) break;
            end
            set_phase(i, 1'b0, 1'b0, 1'b1, 1'b0, p);
            cur[i].cnt = 16'(val);
            cur[i].valid = 1'b1;
            if (!hit) cur[i].terr = 1'b1;
            push(i, 1'b0, bstart, hit);
            if (cur[i].terr || p == NP - 1) begin
                set_phase(i, 1'b0, 1'b0, 1'b0, 1'b1, p);
                push(i, 1'b0, 1'b0, 1'b0);
                return;
            end
        end
    endtask

    task automatic check_log(input int i, input int want [$]);
        n_chk++;
        if (log_q[i].size() == want.size()) n_pass++;
        else $display("FAIL log_len u%0d: got %0d entries, expected %0d", i, log_q[i].size(),
                      want.size());
        for (int k = 0; k < want.size() && k < log_q[i].size(); k++) begin
            n_chk++;
            if (log_q[i][k] == want[k]) n_pass++;
            else $display("FAIL log u%0d[%0d]: got cyc_count=%0d, expected %0d", i, k,
                          log_q[i][k], want[k]);
        end
    endtask

    initial begin
        int    len;
        int    base;
        step_t e;
        obs_t  got;
        int    want [$];
        ini = '0; start = '0; ack = '0;
        for (int i = 0; i < NI; i++) begin
            cur[i] = '0;
            push_init(i); push_init(i); push_idle(i, 2);
        end
        // Default instance: nominal, early ack, abort by init, start while busy, restart from DONE.
        push_run(0, 10, 10, 10, 1'b0, 1'b0); push_idle(0, 3);
        push_run(0, 4, 0, 7, 1'b1, 1'b0);    push_idle(0, 2);
        base = plan[0].size();
        push_run(0, 10, 10, 10, 1'b0, 1'b0);
        while (plan[0].size() > base + 25) void'(plan[0].pop_back());
        push_init(0); push_idle(0, 2);
        push_run(0, 1, 2, 3, 1'b0, 1'b0);    push_idle(0, 2);
        push_run(0, 0, 0, 0, 1'b0, 1'b1);    push_idle(0, 2);
        push_run(0, 5, 5, 5, 1'b0, 1'b0);    push_idle(0, 2);
        // TIMEOUT=20: hung program, then a clean restart clears timeout_err.
        push_run(1, -1, -1, -1, 1'b0, 1'b0); push_idle(1, 4);
        push_run(1, 3, 3, 3, 1'b0, 1'b0);    push_idle(1, 2);
        // CW=4, TIMEOUT=15: timeout at all-ones, then ack coinciding with timeout.
        push_run(2, -1, -1, -1, 1'b0, 1'b0); push_idle(2, 3);
        push_run(2, 13, 12, 0, 1'b0, 1'b0);  push_idle(2, 2);

        len = 0;
        for (int i = 0; i < NI; i++) if (plan[i].size() > len) len = plan[i].size();
        for (int i = 0; i < NI; i++) push_idle(i, len - plan[i].size());

        for (int t = 0; t < len; t++) begin
            for (int i = 0; i < NI; i++) begin
                e = plan[i][t];
                ini[i] = e.rst; start[i] = e.start; ack[i] = e.ack;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NI; i++) begin
                e = plan[i][t];
                got = get_obs(i);
                n_chk++;
                if (got === e.o) n_pass++;
                else $display("FAIL outputs u%0d cycle %0d: got %s ; expected %s", i, t,
                              fmt(got), fmt(e.o));
                if (got.valid === 1'b1) log_q[i].push_back(int'(got.cnt));
            end
        end

        want = '{12, 12, 12, 6, 2, 9, 12, 3, 4, 5, 2, 2, 2, 7, 7, 7};
        check_log(0, want);
        want = '{20, 5, 5, 5};
        check_log(1, want);
        want = '{15, 15, 14, 2};
        check_log(2, want);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
